// File: rtl/sram_arbiter_if.sv
// Bundle of the instruction, data and memory sram-like ports around sram_arbiter.
// slave = arbiter view, master = requesters plus memory.
interface sram_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Handshake: a request is taken in the cycle where *_req and *_addr_ok are
    // both 1. Its completion is the single cycle where *_data_ok is 1, and
    // *_rdata is valid only in that cycle. mem_addr_ok / mem_data_ok follow the
    // same rules on the memory side.
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;

    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    logic              mem_req;
    logic              mem_wr;
    logic [1:0]        mem_size;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok;
    logic              mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  inst_req, inst_addr,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport master (
        output inst_req, inst_addr,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  mem_req, mem_wr, mem_size, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/sram_arbiter.sv
// Shares one sram-like port between instruction fetch and data access, one transaction at a time.
// Define SRAM_ARB_RR_EN for round-robin on conflicts; default is fixed data priority.
module sram_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 flush,
    sram_arbiter_if.slave        bus,
    output logic [1:0]           dbg_state_o
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    logic [1:0]        state_q,  state_d;
    logic              owner_q,  owner_d;
    logic              cancel_q, cancel_d;
    logic              wr_q,     wr_d;
    logic [1:0]        size_q,   size_d;
    logic [ADDR_W-1:0] addr_q,   addr_d;
    logic [DATA_W-1:0] wdata_q,  wdata_d;

    logic in_idle;
    logic inst_ok;
    logic grant_data;
    logic grant_inst;
    logic inst_flush;
    logic resp_done;

    assign in_idle    = (state_q == S_IDLE);
    assign inst_ok    = bus.inst_req & ~flush;
    assign inst_flush = (owner_q == OWN_INST) & flush;

`ifdef SRAM_ARB_RR_EN
    logic last_owner_q;

    // On a conflict, serve whoever did not win the previous grant.
    assign grant_data = bus.data_req & ~(inst_ok & (last_owner_q == OWN_DATA));

    always_ff @(posedge clk) begin
        if (reset) begin
            last_owner_q <= OWN_INST;
        end else if (in_idle && grant_data) begin
            last_owner_q <= OWN_DATA;
        end else if (in_idle && inst_ok) begin
            last_owner_q <= OWN_INST;
        end
    end
`else
    assign grant_data = bus.data_req;
`endif

    assign grant_inst = inst_ok & ~grant_data;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        cancel_d = cancel_q;
        wr_d     = wr_q;
        size_d   = size_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_data) begin
                    state_d = S_REQ;
                    owner_d = OWN_DATA;
                    wr_d    = bus.data_wr;
                    size_d  = bus.data_size;
                    addr_d  = bus.data_addr;
                    wdata_d = bus.data_wdata;
                end else if (grant_inst) begin
                    state_d = S_REQ;
                    owner_d = OWN_INST;
                    wr_d    = 1'b0;
                    size_d  = 2'd2;
                    addr_d  = bus.inst_addr;
                end
            end
            S_REQ: begin
                // A fetch flushed before memory accepts it is simply withdrawn;
                // one flushed in the accept cycle must still drain its response.
                if (bus.mem_addr_ok) begin
                    state_d  = S_RESP;
                    cancel_d = inst_flush;
                end else if (inst_flush) begin
                    state_d = S_IDLE;
                end
            end
            S_RESP: begin
                if (bus.mem_data_ok) begin
                    state_d  = S_IDLE;
                    cancel_d = 1'b0;
                end else if (inst_flush) begin
                    cancel_d = 1'b1;
                end
            end
            default: begin
                state_d  = S_IDLE;
                cancel_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            owner_q  <= OWN_INST;
            cancel_q <= 1'b0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            cancel_q <= cancel_d;
            wr_q     <= wr_d;
            size_q   <= size_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
        end
    end

    assign bus.data_addr_ok = in_idle & grant_data;
    assign bus.inst_addr_ok = in_idle & grant_inst;

    assign bus.mem_req   = (state_q == S_REQ);
    assign bus.mem_wr    = wr_q;
    assign bus.mem_size  = size_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;

    assign resp_done        = (state_q == S_RESP) & bus.mem_data_ok;
    assign bus.data_data_ok = resp_done & (owner_q == OWN_DATA);
    assign bus.inst_data_ok = resp_done & (owner_q == OWN_INST) & ~cancel_q & ~flush;
    assign bus.data_rdata   = bus.mem_rdata;
    assign bus.inst_rdata   = bus.mem_rdata;

    assign dbg_state_o = state_q;
endmodule
